fpu_fmul_pipe: RTL



---
 rtl/fpu_fmul_pipe.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fpu_fmul_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpu_fmul_pipe: 3-stage pipelined floating-point multiplier, RNE, DAZ/FTZ |
// | Optional OUT_FLAGS port enabled by defining FPU_FMUL_FLAGS_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fpu_fmul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [EXP_W+MAN_W:0]   IN_A,
  input  logic [EXP_W+MAN_W:0]   IN_B,
  input  logic [TAG_W-1:0]       IN_TAG,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [EXP_W+MAN_W:0]   OUT_O,
  output logic [TAG_W-1:0]       OUT_TAG
`ifdef FPU_FMUL_FLAGS_EN
  ,
  output logic [3:0]             OUT_FLAGS
`endif
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int XW = EXP_W + 2;

  localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  localparam logic [1:0] CL_NORM = 2'd0;
  localparam logic [1:0] CL_ZERO = 2'd1;
  localparam logic [1:0] CL_INF  = 2'd2;
  localparam logic [1:0] CL_NAN  = 2'd3;

  logic stall;
  assign stall    = OUT_VALID & ~OUT_READY;
  assign IN_READY = ~stall;

  // Stage 1: unpack and classify
  logic             a_sgn, b_sgn;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [1:0]       cls_in;
  logic [XW-1:0]    exp_in;

  assign {a_sgn, a_exp, a_man} = IN_A;
  assign {b_sgn, b_exp, b_man} = IN_B;

  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (&a_exp) & (a_man == '0);
  assign b_inf  = (&b_exp) & (b_man == '0);
  assign a_nan  = (&a_exp) & (|a_man);
  assign b_nan  = (&b_exp) & (|b_man);
  assign exp_in = {2'b00, a_exp} + {2'b00, b_exp} - BIAS;

  always_comb begin
    cls_in = CL_NORM;
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero))
      cls_in = CL_NAN;
    else if (a_inf | b_inf)
      cls_in = CL_INF;
    else if (a_zero | b_zero)
      cls_in = CL_ZERO;
  end

  logic             v1, sgn1;
  logic [1:0]       cls1;
  logic [XW-1:0]    exp1;
  logic [MAN_W:0]   ma1, mb1;
  logic [TAG_W-1:0] tag1;

  logic             v2, sgn2;
  logic [1:0]       cls2;
  logic [XW-1:0]    exp2;
  logic [PW-1:0]    prod2;
  logic [TAG_W-1:0] tag2;

  logic [PW-1:0]    prod_in;
  assign prod_in = {{(MAN_W+1){1'b0}}, ma1} * {{(MAN_W+1){1'b0}}, mb1};

  // Stage 3: normalise, round to nearest even, special-case mux
  logic             norm, guard, sticky, rnd, ovf, unf;
  logic [PW-2:0]    sh;
  logic [MAN_W-1:0] man_t;
  logic [MAN_W:0]   man_r;
  logic [XW-1:0]    exp_f;
  logic [W-1:0]     res;

  assign norm   = prod2[PW-1];
  assign sh     = norm ? prod2[PW-2:0] : {prod2[PW-3:0], 1'b0};
  assign man_t  = sh[PW-2:MAN_W+1];
  assign guard  = sh[MAN_W];
  assign sticky = |sh[MAN_W-1:0];
  assign rnd    = guard & (sticky | man_t[0]);
  assign man_r  = {1'b0, man_t} + {{MAN_W{1'b0}}, rnd};
  assign exp_f  = exp2 + {{(XW-1){1'b0}}, norm} + {{(XW-1){1'b0}}, man_r[MAN_W]};
  // exp_f is signed: negative or zero flushes, at/above all-ones saturates
  assign ovf    = ~exp_f[XW-1] & (exp_f >= EMAX);
  assign unf    = exp_f[XW-1] | (exp_f == '0);

  always_comb begin
    res = '0;
    case (cls2)
      CL_NAN:  res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      CL_INF:  res = {sgn2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CL_ZERO: res = {sgn2, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (ovf)
          res = {sgn2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (unf)
          res = {sgn2, {(EXP_W+MAN_W){1'b0}}};
        else
          res = {sgn2, exp_f[EXP_W-1:0], man_r[MAN_W-1:0]};
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v1        <= 1'b0;
      sgn1      <= 1'b0;
      cls1      <= CL_NORM;
      exp1      <= '0;
      ma1       <= '0;
      mb1       <= '0;
      tag1      <= '0;
      v2        <= 1'b0;
      sgn2      <= 1'b0;
      cls2      <= CL_NORM;
      exp2      <= '0;
      prod2     <= '0;
      tag2      <= '0;
      OUT_VALID <= 1'b0;
      OUT_O     <= '0;
      OUT_TAG   <= '0;
    end else if (!stall) begin
      v1        <= IN_VALID;
      sgn1      <= a_sgn ^ b_sgn;
      cls1      <= cls_in;
      exp1      <= exp_in;
      ma1       <= {1'b1, a_man};
      mb1       <= {1'b1, b_man};
      tag1      <= IN_TAG;
      v2        <= v1;
      sgn2      <= sgn1;
      cls2      <= cls1;
      exp2      <= exp1;
      prod2     <= prod_in;
      tag2      <= tag1;
      OUT_VALID <= v2;
      OUT_O     <= res;
      OUT_TAG   <= tag2;
    end
  end

`ifdef FPU_FMUL_FLAGS_EN
  // {invalid, overflow, underflow, inexact}
  logic [3:0] flags_nx;
  always_comb begin
    flags_nx = 4'b0000;
    case (cls2)
      CL_NAN:  flags_nx = 4'b1000;
      CL_NORM: begin
        if (ovf)
          flags_nx = 4'b0101;
        else if (unf)
          flags_nx = 4'b0011;
        else
          flags_nx = {3'b000, guard | sticky};
      end
      default: flags_nx = 4'b0000;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      OUT_FLAGS <= 4'b0000;
    else if (!stall)
      OUT_FLAGS <= flags_nx;
  end
`endif

endmodule
`default_nettype wire
